serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Bit-serial transmitter. Takes parallel bytes from the Fibonacci/timer datapath and serialises them, MSB first, each byte followed by one even-parity bit.
- It is the transmitting end of the serial link whose receiving end (deserializer with parity check) sits in top.
- A 4-entry input FIFO lets producers burst words while a frame is on the wire.

Parameters:
- DATA_W, 8, data bits per frame.
- FIFO_DEPTH, 4, input FIFO entries; must be a power of 2.
- BIT_DIV, 1, clock cycles per serial bit slot; must be ≥1.
- GAP_CYC, 1, idle cycles between frames; must be ≥1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  parallel word to transmit.
- write_in  in  1  push request; data_in is accepted on an edge where write_in=1 and ack_in=1.
- ack_in  out  1  FIFO not full, write will be accepted; registered.
- overflow  out  1  one-cycle pulse when write_in=1 while ack_in=0; the word is dropped.
- data_out  out  1  current serial bit.
- data_en  out  1  one-cycle strobe; the receiver samples data_out when it is high.
- frame_end  out  1  high together with data_en on the parity slot.
- busy  out  1  high while FSM is not IDLE or FIFO is not empty.

Behaviour:
- Reset values (reset=1 at an edge): FIFO emptied, pointers = 0, FSM = IDLE, div_cnt = 0, bit_cnt = 0. Outputs after reset: ack_in=1, overflow=0, data_out=0, data_en=0, frame_end=0, busy=0.
- Reset wins over every other input on the same edge. Reset mid-frame aborts the frame immediately; no further data_en is issued.
- FIFO:
  - Write pointer advances on an accepted write.
  - Read pointer advances when the FSM loads a word.
  - When the FIFO is full, writes are refused even if a pop occurs on the same edge; ack_in is computed from the registered count.
  - Push and pop on the same edge when not full leave the count unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, load head into shift_reg, compute par = XOR of the word, pop, clear div_cnt and bit_cnt, go to DATA.
  - DATA: data_out = shift_reg[DATA_W-1]; data_en=1 when div_cnt==0. When div_cnt reaches BIT_DIV-1: shift left, bit_cnt+1, div_cnt reset to 0. After bit DATA_W-1, go to PAR.
  - PAR: data_out = par; data_en = frame_end = 1 when div_cnt==0. After BIT_DIV cycles, go to GAP.
  - GAP: data_out=0, no strobes. After GAP_CYC cycles, go to IDLE.
- Timing:
  - Latency: write accepted at the edge ending cycle k with FSM idle → first data_en in cycle k+2.
  - A frame occupies 1 + (DATA_W+1)·BIT_DIV + GAP_CYC cycles, from the load cycle to back in IDLE.
  - Back-to-back words are loaded directly from IDLE with no extra wait.
- Even parity: frame_end bit = 1 iff the data word has an odd number of ones.
- data_out and data_en are registered outputs: no combinational path from data_in or write_in.

Decomposition:
- Package serial_pkg holds:
  - DATA_W default;
  - FSM state encoding S_IDLE, S_DATA, S_PAR, S_GAP;
  - function even_parity(word).
  The matching receiver reuses the same package.
- One natural sub-module: sync_fifo, a parameterised width/depth synchronous FIFO providing full, empty and count outputs.

Test Plan (BIT_DIV=2, GAP_CYC=1 unless noted):
- After reset, write 0xB4 in cycle k:
  - data_en high in cycles k+2, k+4, …, k+18;
  - data_out sequence 1,0,1,1,0,1,0,0 then parity 0;
  - frame_end high only in cycle k+18;
  - busy falls afterwards.
- Write 0x07 → data bits 0,0,0,0,0,1,1,1, parity bit 1; the receiver parity check passes.
- Write 5 words on consecutive cycles (0x01..0x05) starting while idle:
  - 0x01 loads immediately and 0x02..0x05 fill the FIFO;
  - all are accepted, no overflow;
  - a 6th write while 4 entries are queued → ack_in=0, overflow pulses once, the word is dropped;
  - 5 frames are transmitted in order.
- BIT_DIV=1, two words back-to-back: frames are separated by exactly GAP_CYC+1 cycles without data_en.
- Assert reset during bit 3 of a frame:
  - the next cycle has data_en=0 and data_out=0;
  - FIFO is empty, ack_in=1, busy=0;
  - a later write transmits normally.
- Write while full on the same edge the FSM pops: the write is refused and overflow pulses; count goes from 4 to 3.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: frame width, FSM encoding and the
// parity helper used by both the transmitter and the matching receiver.
package serial_pkg;

    localparam int DEF_DATA_W = 8;
    // Widest word even_parity accepts; narrower words are zero-extended,
    // which leaves their parity unchanged.
    localparam int PAR_MAX_W  = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // Even-parity bit: 1 when the word carries an odd number of ones.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Producer-side and line-side signals of the serial transmitter, bundled so
// the producer (master) and the transmitter (slave) share one connection.
interface serial_tx_if
    import serial_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] data_in;
    logic              write_in;
    logic              ack_in;
    logic              overflow;
    logic              data_out;
    logic              data_en;
    logic              frame_end;
    logic              busy;

    modport master (
        output data_in,
        output write_in,
        input  ack_in,
        input  overflow,
        input  data_out,
        input  data_en,
        input  frame_end,
        input  busy
    );

    modport slave (
        input  data_in,
        input  write_in,
        output ack_in,
        output overflow,
        output data_out,
        output data_en,
        output frame_end,
        output busy
    );

endinterface

// File: rtl/serial_tx_sync_fifo.sv
// Parameterised synchronous FIFO with first-word-fall-through head output so
// the transmitter can load and pop in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    // Fullness comes from the registered count, so a pop on the same edge
    // never frees a slot for a simultaneous write.
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    assign rd_data = mem_reg[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Bit-serial transmitter: buffers parallel words in a small FIFO and sends
// each MSB first followed by an even-parity bit, with an idle gap per frame.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int BIT_DIV    = 1,
    parameter int GAP_CYC    = 1
) (
    input logic        clock,
    input logic        reset,
    serial_tx_if.slave bus
);

    localparam int CNT_MAX = (BIT_DIV > GAP_CYC) ? BIT_DIV : GAP_CYC;
    localparam int DIV_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(GAP_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    logic [DATA_W-1:0]    fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FCNT_W-1:0]    fifo_count;
    logic                 fifo_pop;
    logic [PAR_MAX_W-1:0] head_wide;

    state_t               state_reg;
    logic [DIV_W-1:0]     div_cnt_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic [DATA_W-1:0]    shift_reg;
    logic                 par_reg;
    logic                 data_out_reg;
    logic                 data_en_reg;
    logic                 frame_end_reg;
    logic                 overflow_reg;

    assign fifo_pop = (state_reg == S_IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .srst    (reset),
        .wr_en   (bus.write_in),
        .wr_data (bus.data_in),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        head_wide = '0;
        head_wide[DATA_W-1:0] = fifo_head;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= bus.write_in && fifo_full;
        end
    end

    // Line outputs are registered from the next-state values, so each
    // strobe appears in the first cycle of its bit slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            div_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            par_reg       <= 1'b0;
            data_out_reg  <= 1'b0;
            data_en_reg   <= 1'b0;
            frame_end_reg <= 1'b0;
        end else begin
            data_en_reg   <= 1'b0;
            frame_end_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg    <= fifo_head;
                        par_reg      <= even_parity(head_wide);
                        div_cnt_reg  <= '0;
                        bit_cnt_reg  <= '0;
                        state_reg    <= S_DATA;
                        data_out_reg <= fifo_head[DATA_W-1];
                        data_en_reg  <= 1'b1;
                    end else begin
                        data_out_reg <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (div_cnt_reg == DIV_LAST) begin
                        div_cnt_reg <= '0;
                        shift_reg   <= shift_reg << 1;
                        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        data_en_reg <= 1'b1;
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_reg     <= S_PAR;
                            data_out_reg  <= par_reg;
                            frame_end_reg <= 1'b1;
                        end else begin
                            data_out_reg <= shift_reg[DATA_W-2];
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                S_PAR: begin
                    if (div_cnt_reg == DIV_LAST) begin
                        state_reg    <= S_GAP;
                        div_cnt_reg  <= '0;
                        data_out_reg <= 1'b0;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                S_GAP: begin
                    if (div_cnt_reg == GAP_LAST) begin
                        state_reg   <= S_IDLE;
                        div_cnt_reg <= '0;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_in    = (fifo_count != FCNT_W'(FIFO_DEPTH));
    assign bus.overflow  = overflow_reg;
    assign bus.data_out  = data_out_reg;
    assign bus.data_en   = data_en_reg;
    assign bus.frame_end = frame_end_reg;
    assign bus.busy      = (state_reg != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: table of single frames plus hand-written
// sequences for FIFO fill/overflow, back-to-back frames and mid-frame reset.
module tb_serial_tx;

    typedef struct {
        int   cyc;
        logic b;
        logic fe;
    } strobe_t;

    typedef struct {
        logic [7:0] data;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    strobe_t q2[$];
    strobe_t q1[$];
    strobe_t cap[$];

    serial_tx_if #(.DATA_W(8)) if2();
    serial_tx_if #(.DATA_W(8)) if1();

    serial_tx #(.DATA_W(8), .FIFO_DEPTH(4), .BIT_DIV(2), .GAP_CYC(1)) dut2 (
        .clock (clk),
        .reset (rst),
        .bus   (if2)
    );

    serial_tx #(.DATA_W(8), .FIFO_DEPTH(4), .BIT_DIV(1), .GAP_CYC(1)) dut1 (
        .clock (clk),
        .reset (rst),
        .bus   (if1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (if2.data_en) q2.push_back('{cyc, if2.data_out, if2.frame_end});
            if (if1.data_en) q1.push_back('{cyc, if1.data_out, if1.frame_end});
        end
    end

    task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Caller sits just after a rising edge; write_in is held for one cycle.
    task automatic push(input int sel, input logic [7:0] d, output int k);
        k = cyc;
        if (sel != 0) begin if1.data_in = d; if1.write_in = 1'b1; end
        else begin if2.data_in = d; if2.write_in = 1'b1; end
        @(posedge clk); #1;
        if1.write_in = 1'b0;
        if2.write_in = 1'b0;
    endtask

    task automatic wait_idle(input int sel, input int limit, input string nm);
        int n = 0;
        logic b;
        do begin
            @(negedge clk);
            n++;
            b = (sel != 0) ? if1.busy : if2.busy;
        end while (b && n < limit);
        check_val({nm, " busy falls"}, 32'(b), 32'd0);
    endtask

    task automatic check_frame(input int base, input logic [8:0] exp, input int first,
                               input int div, input string nm);
        logic [8:0] bits;
        logic [8:0] fe;
        int         bad_t;
        bits  = '0;
        fe    = '0;
        bad_t = -1;
        if (cap.size() < base + 9) begin
            check_val({nm, " strobe count"}, 32'(cap.size()), 32'(base + 9));
            return;
        end
        for (int i = 0; i < 9; i++) begin
            bits[8-i] = cap[base+i].b;
            fe[8-i]   = cap[base+i].fe;
            if (bad_t < 0 && cap[base+i].cyc != first + i * div) bad_t = i;
        end
        check_val({nm, " bits"}, 32'(bits), 32'(exp));
        check_val({nm, " frame_end"}, 32'(fe), 32'h001);
        check_val({nm, " timing"},
                  32'((bad_t < 0) ? first : cap[base+bad_t].cyc - bad_t * div), 32'(first));
    endtask

    vec_t vecs[4];
    logic [8:0] burst_exp[5];

    initial begin
        int k;
        int k2;
        vecs[0] = '{8'hB4, 9'h168};
        vecs[1] = '{8'h07, 9'h00F};
        vecs[2] = '{8'hFF, 9'h1FE};
        vecs[3] = '{8'h80, 9'h101};
        burst_exp[0] = 9'h003;
        burst_exp[1] = 9'h005;
        burst_exp[2] = 9'h006;
        burst_exp[3] = 9'h009;
        burst_exp[4] = 9'h00A;

        if1.data_in = '0; if1.write_in = 1'b0;
        if2.data_in = '0; if2.write_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("reset ack_in", 32'(if2.ack_in), 32'd1);
        check_val("reset overflow", 32'(if2.overflow), 32'd0);
        check_val("reset data_out", 32'(if2.data_out), 32'd0);
        check_val("reset data_en", 32'(if2.data_en), 32'd0);
        check_val("reset frame_end", 32'(if2.frame_end), 32'd0);
        check_val("reset busy", 32'(if2.busy), 32'd0);
        @(posedge clk); #1;

        // Single frames, BIT_DIV=2: strobes at k+2, k+4, ..., k+18.
        for (int v = 0; v < 4; v++) begin
            q2.delete();
            push(0, vecs[v].data, k);
            wait_idle(0, 60, $sformatf("vec%0d", v));
            cap = q2;
            check_val($sformatf("vec%0d strobes", v), 32'(cap.size()), 32'd9);
            check_frame(0, vecs[v].exp, k + 2, 2, $sformatf("vec%0d", v));
            @(posedge clk); #1;
        end

        // Five-word burst, a sixth write into a full FIFO, then a write
        // on the very edge the FSM pops the second word.
        q2.delete();
        k = cyc;
        for (int i = 0; i < 6; i++) begin
            if2.data_in  = (i < 5) ? 8'(i + 1) : 8'h66;
            if2.write_in = 1'b1;
            @(negedge clk);
            check_val($sformatf("burst%0d ack_in", i), 32'(if2.ack_in), (i < 5) ? 32'd1 : 32'd0);
            check_val($sformatf("burst%0d overflow", i), 32'(if2.overflow), 32'd0);
            @(posedge clk); #1;
        end
        if2.write_in = 1'b0;
        @(negedge clk);
        check_val("full write overflow pulse", 32'(if2.overflow), 32'd1);
        @(negedge clk);
        check_val("overflow single pulse", 32'(if2.overflow), 32'd0);
        repeat (k + 21 - cyc) @(posedge clk);
        #1;
        if2.data_in  = 8'h77;
        if2.write_in = 1'b1;
        @(negedge clk);
        check_val("pop edge ack_in before", 32'(if2.ack_in), 32'd0);
        @(posedge clk); #1;
        if2.write_in = 1'b0;
        @(negedge clk);
        check_val("pop edge overflow", 32'(if2.overflow), 32'd1);
        check_val("pop edge ack_in after", 32'(if2.ack_in), 32'd1);
        wait_idle(0, 200, "burst");
        cap = q2;
        check_val("burst strobes", 32'(cap.size()), 32'd45);
        for (int j = 0; j < 5; j++) begin
            check_frame(9 * j, burst_exp[j], k + 2 + 20 * j, 2, $sformatf("burst frame%0d", j));
        end
        @(posedge clk); #1;

        // BIT_DIV=1 back-to-back: GAP_CYC+1 quiet cycles between frames.
        q1.delete();
        push(1, 8'hA5, k);
        push(1, 8'h3D, k2);
        wait_idle(1, 60, "b2b");
        cap = q1;
        check_val("b2b strobes", 32'(cap.size()), 32'd18);
        check_frame(0, 9'h14A, k + 2, 1, "b2b frame0");
        check_frame(9, 9'h07B, k + 13, 1, "b2b frame1");
        if (cap.size() >= 10) begin
            check_val("b2b quiet cycles", 32'(cap[9].cyc - cap[8].cyc - 1), 32'd2);
        end else begin
            check_val("b2b quiet cycles", 32'(cap.size()), 32'd10);
        end
        @(posedge clk); #1;

        // Reset while bit 3 is on the wire, with two more words queued.
        q2.delete();
        push(0, 8'hC3, k);
        push(0, 8'h11, k2);
        push(0, 8'h22, k2);
        repeat (k + 8 - cyc) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("abort data_en", 32'(if2.data_en), 32'd0);
        check_val("abort data_out", 32'(if2.data_out), 32'd0);
        check_val("abort ack_in", 32'(if2.ack_in), 32'd1);
        check_val("abort busy", 32'(if2.busy), 32'd0);
        repeat (30) @(negedge clk);
        check_val("abort strobes", 32'(q2.size()), 32'd4);
        @(posedge clk); #1;
        push(0, 8'h5A, k);
        wait_idle(0, 60, "after abort");
        cap = q2;
        check_frame(4, 9'h0B4, k + 2, 2, "after abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
